vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter WRBUF_DEPTH, default 4, CPU write-buffer entries; power of two, 2..8.
REQ-002 Parameter BORDER_RST, default 12'h000, border colour after reset.
REQ-003 CLOCK  in  1  single clock; all logic on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 vaddr  in  16  video read address from the display adapter.
REQ-006 vdata  out  8  video read data to the display adapter.
REQ-007 cpu_addr  in  16  CPU memory address.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_we  in  1  CPU write request; qualified by cpu_ready.
REQ-010 cpu_rd  in  1  CPU read request; qualified by cpu_ready.
REQ-011 cpu_rdata  out  8  CPU read data; valid in the cycle cpu_ready completes a read.
REQ-012 cpu_ready  out  1  request accepted/completed this cycle.
REQ-013 port_we  in  1  border port write strobe.
REQ-014 port_data  in  12  border colour value.
REQ-015 border  out  12  registered border colour to the display adapter.
REQ-016 ram_addr  out  16, ram_wdata  out  8, ram_we  out  1: single-port synchronous RAM controls.
REQ-017 ram_rdata  in  8  RAM read data, one cycle after the address is presented.

Function
REQ-018 A slot bit toggles every cycle; slot 0 = VIDEO, slot 1 = CPU; RESET sets it to VIDEO.
REQ-019 In VIDEO slot: ram_addr=vaddr, ram_we=0; vdata loads ram_rdata the following cycle and holds until the next VIDEO result (vaddr->vdata latency 2 cycles, stable 2 cycles).
REQ-020 The VIDEO slot is never granted to the CPU; video bandwidth is unconditional.
REQ-021 In CPU slot: if the write buffer is non-empty, pop the oldest entry and write it (ram_we=1); otherwise, if a read is pending, issue it (ram_we=0); otherwise idle (ram_we=0).
REQ-022 CPU state machine: IDLE -> RD_WAIT on cpu_rd with no read pending; RD_WAIT -> RD_DATA when the read is issued; RD_DATA -> IDLE with cpu_ready=1 and cpu_rdata=ram_rdata.
REQ-023 Reads wait until the write buffer is empty, so a read following a write to the same address returns the new data.
REQ-024 Write: cpu_ready=1 in the same cycle as cpu_we if the buffer is not full; the {addr,data} entry is pushed.
REQ-025 Buffer full: cpu_ready=0 for the write until a CPU-slot pop; push and pop in the same cycle are allowed and leave occupancy unchanged.
REQ-026 cpu_we and cpu_rd asserted together: the write takes priority; the read is not registered that cycle.
REQ-027 port_we loads border<=port_data on the next edge; this path is independent of the slot.

Reset
REQ-028 RESET: slot=VIDEO, CPU FSM=IDLE, buffer empty, cpu_ready=0, cpu_rdata=0, vdata=0, ram_we=0, ram_addr=0, ram_wdata=0, border=BORDER_RST.
REQ-029 RESET asserted mid-read or with writes buffered discards them; no RAM write is issued in the reset cycle or the cycle after.

Configuration
REQ-030 Macro VRAM_WRBUF_EN defined: the write buffer is present as specified above.
REQ-031 VRAM_WRBUF_EN undefined: no buffer; a write is held (cpu_ready=0) until the next CPU slot, then written with cpu_ready=1 in that cycle; the WRBUF_DEPTH parameter is ignored.

Structure
REQ-032 Package vram_pkg holds the slot enum (VIDEO/CPU), the CPU FSM state enum (IDLE/RD_WAIT/RD_DATA), the write-entry struct {addr[15:0],data[7:0]} and the default BORDER_RST.
REQ-033 One sub-module, vram_wrbuf: a synchronous FIFO with push/pop/full/empty, instantiated only under VRAM_WRBUF_EN.

Verification
REQ-034 RAM[4000h]=A5, vaddr=4000h held -> vdata=A5 two cycles after the VIDEO slot; ram_we never 1 in a VIDEO slot.
REQ-035 Writes 55,66,77,88 to 4001h..4004h in four back-to-back cycles -> cpu_ready=1 each cycle; RAM written in order in the next four CPU slots.
REQ-036 Fifth back-to-back write with the buffer full -> cpu_ready=0 until the first CPU-slot pop, then accepted.
REQ-037 Write 3Ch to 5000h, then read 5000h immediately -> the read completes after the buffer drains, with cpu_rdata=3Ch.
REQ-038 port_we with port_data=12'hF80 -> border=F80 the next cycle; RESET asserted while RD_WAIT -> FSM=IDLE, border=BORDER_RST, buffer empty.
REQ-039 Build without VRAM_WRBUF_EN: each write stalls at most 1 cycle, RAM contents match those of the buffered build.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: slot phase, CPU read FSM states,
// the buffered write entry and the default border colour after reset.
package vram_pkg;

    // Alternating RAM access phase; VIDEO owns even cycles after reset.
    typedef enum logic {
        VIDEO = 1'b0,
        CPU   = 1'b1
    } slot_e;

    // CPU read sequencing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } cpu_state_e;

    // One posted CPU write.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

    localparam logic [11:0] BORDER_RST_DEFAULT = 12'h000;

endpackage

// File: rtl/vram_wrbuf.sv
// Synchronous FIFO of posted CPU writes. DEPTH must be a power of two so the
// pointers wrap naturally. A push is taken while full only when a pop happens
// in the same cycle, which leaves the occupancy unchanged.
module vram_wrbuf
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    wr_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign head  = mem_q[rptr_q];

    // Qualify push/pop against occupancy and advance pointers and count.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: time-slices one synchronous single-port RAM between the
// display adapter (VIDEO slot) and the CPU (CPU slot), plus the border
// colour register. Build option VRAM_WRBUF_EN adds a posted write buffer
// (vram_wrbuf); without it a CPU write stalls until the next CPU slot.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int          WRBUF_DEPTH = 4,
    parameter logic [11:0] BORDER_RST  = BORDER_RST_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] vaddr,
    output logic [7:0]  vdata,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic        port_we,
    input  logic [11:0] port_data,
    output logic [11:0] border,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    slot_e       slot_q, slot_d;
    cpu_state_e  state_q, state_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  vdata_q, vdata_d;
    logic [11:0] border_q, border_d;

    wr_entry_t   wr_head;     // entry written to RAM this CPU slot
    logic        wr_pop;      // a CPU-slot RAM write happens this cycle
    logic        wr_accept;   // the CPU write is acknowledged this cycle
    logic        buf_empty;   // no posted writes outstanding
    logic        rd_issue;    // pending read goes to RAM this cycle

`ifdef VRAM_WRBUF_EN
    wr_entry_t   wr_in;
    logic        wr_push;
    logic        wr_full;
    logic        wr_empty;

    assign wr_in     = '{addr: cpu_addr, data: cpu_wdata};
    assign buf_empty = wr_empty;

    // Writes are posted only while no read is in flight; a full buffer
    // still accepts when the CPU slot frees an entry in the same cycle.
    always_comb begin
        wr_pop    = (slot_q == CPU) && !wr_empty && !RESET;
        wr_accept = (state_q == IDLE) && cpu_we && (!wr_full || wr_pop) && !RESET;
        wr_push   = wr_accept;
    end

    vram_wrbuf #(
        .DEPTH      (WRBUF_DEPTH)
    ) u_wrbuf (
        .clk        (CLOCK),
        .rst        (RESET),
        .push       (wr_push),
        .push_entry (wr_in),
        .pop        (wr_pop),
        .head       (wr_head),
        .full       (wr_full),
        .empty      (wr_empty)
    );
`else
    logic unused_wrbuf_depth;

    assign unused_wrbuf_depth = ^WRBUF_DEPTH;
    assign buf_empty          = 1'b1;

    // Without a buffer the write goes straight to RAM in the CPU slot and is
    // acknowledged in that same cycle.
    always_comb begin
        wr_head   = '{addr: cpu_addr, data: cpu_wdata};
        wr_pop    = (slot_q == CPU) && (state_q == IDLE) && cpu_we && !RESET;
        wr_accept = wr_pop;
    end
`endif

    // A pending read uses the CPU slot only once all earlier writes are in RAM.
    always_comb begin
        rd_issue = (slot_q == CPU) && (state_q == RD_WAIT) && buf_empty && !wr_pop && !RESET;
    end

    // RAM port mux: VIDEO slot reads vaddr, CPU slot writes, reads or idles.
    always_comb begin
        ram_addr  = 16'h0000;
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
        if (!RESET) begin
            if (slot_q == VIDEO) begin
                ram_addr = vaddr;
            end else if (wr_pop) begin
                ram_addr  = wr_head.addr;
                ram_wdata = wr_head.data;
                ram_we    = 1'b1;
            end else if (rd_issue) begin
                ram_addr = rd_addr_q;
            end
        end
    end

    // CPU read FSM; a write in the same cycle as a read wins and drops it.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_rd && !cpu_we) begin
                    state_d   = RD_WAIT;
                    rd_addr_d = cpu_addr;
                end
            end
            RD_WAIT: begin
                if (rd_issue) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                state_d = IDLE;
                rdata_d = ram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot toggle, video data capture (the cycle after a VIDEO slot) and border.
    always_comb begin
        slot_d   = (slot_q == VIDEO) ? CPU : VIDEO;
        vdata_d  = (slot_q == CPU) ? ram_rdata : vdata_q;
        border_d = port_we ? port_data : border_q;
    end

    // State registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            slot_q    <= VIDEO;
            state_q   <= IDLE;
            rd_addr_q <= 16'h0000;
            rdata_q   <= 8'h00;
            vdata_q   <= 8'h00;
            border_q  <= BORDER_RST;
        end else begin
            slot_q    <= slot_d;
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            vdata_q   <= vdata_d;
            border_q  <= border_d;
        end
    end

    // Read data is live from RAM in the completing cycle, then held.
    always_comb begin
        cpu_ready = !RESET && (wr_accept || (state_q == RD_DATA));
        if (RESET) begin
            cpu_rdata = 8'h00;
        end else if (state_q == RD_DATA) begin
            cpu_rdata = ram_rdata;
        end else begin
            cpu_rdata = rdata_q;
        end
    end

    assign vdata  = vdata_q;
    assign border = border_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM.
// Builds with or without VRAM_WRBUF_EN; buffer-specific expectations are
// guarded by the same macro.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam logic [11:0] BRST = 12'h0A5;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [15:0] vaddr;
    logic [7:0]  vdata;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        port_we;
    logic [11:0] port_data;
    logic [11:0] border;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:65535];
    logic        phase;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          vid_we_viol = 0;
    logic [23:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    vram_arbiter #(
        .WRBUF_DEPTH (4),
        .BORDER_RST  (BRST)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .vaddr     (vaddr),
        .vdata     (vdata),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rd    (cpu_rd),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .port_we   (port_we),
        .port_data (port_data),
        .border    (border),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge CLOCK) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Expected slot: 0 = VIDEO, starting VIDEO after a reset edge.
    always @(posedge CLOCK) begin
        phase <= RESET ? 1'b0 : ~phase;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: records accepted writes, checks every RAM write and read result.
    always @(negedge CLOCK) begin
        if (RESET) begin
            exp_wr_q.delete();
            check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        end else begin
            if (cpu_we === 1'b1 && cpu_ready === 1'b1)
                exp_wr_q.push_back({cpu_addr, cpu_wdata});
            if (ram_we === 1'b1) begin
                if (phase == 1'b0) vid_we_viol++;
                if (exp_wr_q.size() == 0) fail_now("ram_write_unexpected");
                else check("ram_write_order", {8'h0, ram_addr, ram_wdata}, {8'h0, exp_wr_q.pop_front()});
            end
            if (cpu_ready === 1'b1 && cpu_rd === 1'b1 && cpu_we !== 1'b1) begin
                if (exp_rd_q.size() == 0) fail_now("cpu_read_unexpected");
                else check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, exp_rd_q.pop_front()});
            end
            if (cpu_ready === 1'b1 && cpu_rd !== 1'b1 && cpu_we !== 1'b1)
                fail_now("cpu_ready_spurious");
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            output int waits, output logic we_at_accept);
        logic got;
        got          = 1'b0;
        waits        = 0;
        we_at_accept = 1'b0;
        cpu_addr     = a;
        cpu_wdata    = d;
        cpu_we       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (cpu_ready === 1'b1) begin
                got          = 1'b1;
                we_at_accept = ram_we;
                break;
            end
            waits++;
        end
        if (!got) fail_now("write_timeout");
        @(posedge CLOCK);
        #1;
        cpu_we = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] expd);
        logic got;
        got = 1'b0;
        exp_rd_q.push_back(expd);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK);
            if (cpu_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("read_timeout");
            exp_rd_q.delete();
        end
        @(posedge CLOCK);
        #1;
        cpu_rd = 1'b0;
    endtask

    task automatic write_checked(input logic [15:0] a, input logic [7:0] d, output int waits);
        logic we_acc;
        do_write(a, d, waits, we_acc);
`ifdef VRAM_WRBUF_EN
        if (waits > 0) check("stall_release_on_pop", {31'b0, we_acc}, 32'd1);
`else
        check("unbuf_stall_le1", {31'b0, waits <= 1}, 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h4000] = 8'hA5;
        mem[16'h4010] = 8'h5A;
        RESET     = 1'b1;
        vaddr     = 16'h4000;
        cpu_addr  = 16'h0;
        cpu_wdata = 8'h0;
        cpu_we    = 1'b0;
        cpu_rd    = 1'b0;
        port_we   = 1'b0;
        port_data = 12'h0;

        // Reset state.
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_border", {20'h0, border}, {20'h0, BRST});
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'd0);
        check("rst_vdata", {24'h0, vdata}, 32'd0);
        check("rst_ram_addr", {16'h0, ram_addr}, 32'd0);
        check("rst_ram_wdata", {24'h0, ram_wdata}, 32'd0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;

        // Video path: C0 VIDEO, C1 CPU, vdata visible in C2 and C3.
        @(negedge CLOCK);
        check("video_ram_addr", {16'h0, ram_addr}, 32'h4000);
        check("vdata_c0", {24'h0, vdata}, 32'd0);
        @(negedge CLOCK);
        check("vdata_c1", {24'h0, vdata}, 32'd0);
        @(negedge CLOCK);
        check("vdata_c2", {24'h0, vdata}, 32'hA5);
        @(negedge CLOCK);
        check("vdata_c3", {24'h0, vdata}, 32'hA5);
        @(posedge CLOCK);
        #1;
        vaddr = 16'h4010;
        @(negedge CLOCK);
        @(negedge CLOCK);
        check("vdata_c5_hold", {24'h0, vdata}, 32'hA5);
        @(negedge CLOCK);
        check("vdata_c6_new", {24'h0, vdata}, 32'h5A);

        // Border port.
        @(posedge CLOCK);
        #1;
        port_we   = 1'b1;
        port_data = 12'hF80;
        @(negedge CLOCK);
        check("border_before_edge", {20'h0, border}, {20'h0, BRST});
        @(posedge CLOCK);
        #1;
        port_we = 1'b0;
        check("border_loaded", {20'h0, border}, 32'hF80);

        // Four back-to-back writes.
        for (int i = 0; i < 4; i++) begin
            write_checked(16'h4001 + 16'(i), 8'h55 + 8'(i * 8'h11), w);
`ifdef VRAM_WRBUF_EN
            check("wr4_ready_immediate", w, 0);
`endif
        end
        repeat (12) @(posedge CLOCK);
        #1;

        // Long burst to fill the buffer.
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            write_checked(16'h7000 + 16'(i), 8'h90 + 8'(i), w);
            if (w > 0) stalls++;
        end
`ifdef VRAM_WRBUF_EN
        check("burst_saw_full_stall", {31'b0, stalls > 0}, 32'd1);
`endif
        repeat (12) @(posedge CLOCK);
        #1;

        // Read immediately after a write to the same address.
        write_checked(16'h5000, 8'h3C, w);
        do_read(16'h5000, 8'h3C);
        do_read(16'h4001, 8'h55);

        // Write and read together: the write wins, the read is dropped.
        cpu_rd = 1'b1;
        write_checked(16'h4005, 8'hC3, w);
        cpu_rd = 1'b0;
        repeat (8) @(posedge CLOCK);
        #1;

        // Reset with writes posted and a read waiting.
        write_checked(16'h6000, 8'h11, w);
        write_checked(16'h6001, 8'h22, w);
        cpu_addr = 16'h6000;
        cpu_rd   = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET  = 1'b1;
        cpu_rd = 1'b0;
        @(negedge CLOCK);
        check("rst_mid_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("post_rst_border", {20'h0, border}, {20'h0, BRST});
        check("post_rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("post_rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        repeat (6) @(posedge CLOCK);
        #1;
        do_read(16'h4002, 8'h66);
        write_checked(16'h4006, 8'hE7, w);
`ifdef VRAM_WRBUF_EN
        check("post_rst_buf_empty_ready", w, 0);
`endif
        repeat (12) @(posedge CLOCK);
        @(negedge CLOCK);

        // Final RAM contents and bookkeeping.
        check("mem_4001", {24'h0, mem[16'h4001]}, 32'h55);
        check("mem_4002", {24'h0, mem[16'h4002]}, 32'h66);
        check("mem_4003", {24'h0, mem[16'h4003]}, 32'h77);
        check("mem_4004", {24'h0, mem[16'h4004]}, 32'h88);
        check("mem_4005", {24'h0, mem[16'h4005]}, 32'hC3);
        check("mem_4006", {24'h0, mem[16'h4006]}, 32'hE7);
        check("mem_5000", {24'h0, mem[16'h5000]}, 32'h3C);
        for (int i = 0; i < 12; i++)
            check("mem_burst", {24'h0, mem[16'h7000 + i]}, {24'h0, 8'h90 + 8'(i)});
        check("ram_we_in_video_slot", vid_we_viol, 0);
        check("writes_outstanding", exp_wr_q.size(), 0);
        check("reads_outstanding", exp_rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
